// File: rtl/rom_loader.sv
// rom_loader: parses a byte stream of frames {slot, len_lo, len_hi, payload...}
// coming from the SPI bridge and turns every payload byte into one write on the
// ROM/RAM array port. A per-slot "loaded" mask tells the memory map which ROM
// images are complete and error-free.
//
// Optional feature: define CHECKSUM_EN to expect one trailer byte after the
// payload holding the mod-256 sum of the payload. A mismatching trailer marks
// the frame as failed so the slot is not flagged as loaded.
module rom_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16384,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int SLOTS         = 16,
  parameter int SLOT_WIDTH    = $clog2(SLOTS)
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              abort,
  output logic                              wr_en,
  output logic [SLOT_WIDTH+ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [SLOTS-1:0]                  loaded
);

  // Length field is two stream bytes; the remaining counter must also hold
  // DEPTH itself (encoded as length 0), so give it one spare bit.
  localparam int LEN_W = 2 * DATA_WIDTH;
  localparam int CNT_W = ((LEN_W > ADDRESS_WIDTH) ? LEN_W : ADDRESS_WIDTH) + 1;
  // Offset carries one extra bit so "ran past the end of the slot" is visible
  // without ever wrapping into the neighbouring slot.
  localparam int OFF_W = ADDRESS_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [SLOT_WIDTH-1:0]   slot;
  logic                    slot_bad;
  logic [DATA_WIDTH-1:0]   len_lo;
  logic [CNT_W-1:0]        remaining;
  logic [OFF_W-1:0]        offset;
  logic [LEN_W-1:0]        len_full;

  logic                    accept;
  logic                    do_write;
  logic                    off_full;
  logic                    last_byte;

`ifdef CHECKSUM_EN
  logic [7:0]              sum;
`endif

  // Handshake and status outputs are pure decodes of the state; reset forces
  // them low so nothing is accepted or reported while resetn is held.
  assign in_ready  = resetn && (state != DONE);
  assign busy      = resetn && (state != IDLE);
  assign done      = resetn && (state == DONE) && !abort;

  // abort outranks a same-cycle byte: the byte is left on the stream.
  assign accept    = in_valid && in_ready && !abort;
  assign off_full  = (32'(offset) >= DEPTH);
  assign last_byte = (remaining == CNT_W'(1));
  assign len_full  = {in_data, len_lo};

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and write decision for the current byte.
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (accept) state_next = DATA;
      end
      DATA: begin
        if (accept) begin
          // Bytes for an invalid slot or past the slot end are swallowed.
          do_write = !slot_bad && !off_full;
          if (last_byte) begin
`ifdef CHECKSUM_EN
            state_next = CHK;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef CHECKSUM_EN
      CHK: begin
        if (accept) state_next = DONE;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort) state_next = IDLE;
  end

  // Frame bookkeeping, RAM write port and status registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err       <= 1'b0;
      loaded    <= '0;
      slot      <= '0;
      slot_bad  <= 1'b0;
      len_lo    <= '0;
      remaining <= '0;
      offset    <= '0;
`ifdef CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= {slot, offset[ADDRESS_WIDTH-1:0]};
        wr_data <= in_data;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            // A new frame clears the previous error, unless the slot is bad.
            slot     <= in_data[SLOT_WIDTH-1:0];
            slot_bad <= (32'(in_data) >= SLOTS);
            err      <= (32'(in_data) >= SLOTS);
          end
        end
        LEN_LO: begin
          if (accept) len_lo <= in_data;
        end
        LEN_HI: begin
          if (accept) begin
            remaining <= (len_full == '0) ? CNT_W'(DEPTH) : CNT_W'(len_full);
            offset    <= '0;
`ifdef CHECKSUM_EN
            sum       <= '0;
`endif
            // The slot's old image is being overwritten from here on.
            if (!slot_bad) loaded[slot] <= 1'b0;
          end
        end
        DATA: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (do_write) offset <= offset + OFF_W'(1);
            if (!slot_bad && off_full) err <= 1'b1;
`ifdef CHECKSUM_EN
            sum <= sum + in_data[7:0];
`endif
          end
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (accept && (in_data[7:0] != sum)) err <= 1'b1;
        end
`endif
        DONE: begin
          if (!abort && !err) loaded[slot] <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: reset values, normal frame, full-slot frame,
// invalid slot, oversize frame, abort, mid-frame reset and (when CHECKSUM_EN
// is defined) trailer checking.
module tb_rom_loader;

  logic        clk;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] loaded;

  int checks   = 0;
  int failures = 0;
  int wr_total   = 0;
  int done_total = 0;

  rom_loader dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .abort    (abort),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .loaded   (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write strobes and done pulses, one per cycle, mid-cycle.
  always @(negedge clk) begin
    if (wr_en) wr_total++;
    if (done)  done_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the edge where it is accepted.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Trailer byte exists only in the checksum build.
  task automatic finish_frame(input logic [7:0] trailer);
`ifdef CHECKSUM_EN
    send(trailer);
`else
    if (trailer === 8'hxx) $display("unused trailer");
`endif
  endtask

  initial begin
    logic [7:0] p1 [4];
    int w0;
    int d0;
    p1[0] = 8'hAA; p1[1] = 8'hBB; p1[2] = 8'hCC; p1[3] = 8'hDD;

    resetn   = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    abort    = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en",    {31'b0, wr_en}, 32'd0);
    check("rst_wr_addr",  {14'b0, wr_addr}, 32'd0);
    check("rst_wr_data",  {24'b0, wr_data}, 32'd0);
    check("rst_busy",     {31'b0, busy}, 32'd0);
    check("rst_done",     {31'b0, done}, 32'd0);
    check("rst_err",      {31'b0, err}, 32'd0);
    check("rst_loaded",   {16'b0, loaded}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("idle_busy",     {31'b0, busy}, 32'd0);

    // Normal frame: slot 3, four bytes
    w0 = wr_total; d0 = done_total;
    send(8'h03);
    check("f1_busy", {31'b0, busy}, 32'd1);
    send(8'h04);
    send(8'h00);
    for (int i = 0; i < 4; i++) begin
      send(p1[i]);
      check("f1_wr_en",   {31'b0, wr_en}, 32'd1);
      check("f1_wr_addr", {14'b0, wr_addr}, 32'h0C000 + i);
      check("f1_wr_data", {24'b0, wr_data}, {24'b0, p1[i]});
    end
    finish_frame(8'h0E);
    check("f1_done",     {31'b0, done}, 32'd1);
    check("f1_ready_lo", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("f1_done_off", {31'b0, done}, 32'd0);
    check("f1_loaded",   {16'b0, loaded}, 32'h0008);
    check("f1_err",      {31'b0, err}, 32'd0);
    check("f1_writes",   wr_total - w0, 32'd4);
    check("f1_dones",    done_total - d0, 32'd1);

    // Full slot: slot 5, L=0 means 16384 bytes
    w0 = wr_total;
    send(8'h05);
    send(8'h00);
    send(8'h00);
    for (int i = 0; i < 16384; i++) send(8'(i));
    check("f2_last_wr_en", {31'b0, wr_en}, 32'd1);
    check("f2_last_addr",  {14'b0, wr_addr}, 32'h17FFF);
    check("f2_last_data",  {24'b0, wr_data}, 32'h000000FF);
    finish_frame(8'h00);
    check("f2_done", {31'b0, done}, 32'd1);
    @(posedge clk);
    #1;
    check("f2_loaded", {16'b0, loaded}, 32'h0028);
    check("f2_writes", wr_total - w0, 32'd16384);

    // Invalid slot 0x14: payload consumed, no writes
    w0 = wr_total; d0 = done_total;
    send(8'h14);
    check("f3_err_set", {31'b0, err}, 32'd1);
    send(8'h02);
    send(8'h00);
    send(8'hAA);
    check("f3_no_wr0", {31'b0, wr_en}, 32'd0);
    send(8'hBB);
    check("f3_no_wr1", {31'b0, wr_en}, 32'd0);
    finish_frame(8'h00);
    @(posedge clk);
    #1;
    check("f3_err",    {31'b0, err}, 32'd1);
    check("f3_loaded", {16'b0, loaded}, 32'h0028);
    check("f3_writes", wr_total - w0, 32'd0);
    check("f3_dones",  done_total - d0, 32'd1);

    // Oversize: slot 1, L=16385
    w0 = wr_total;
    send(8'h01);
    check("f4_err_clr", {31'b0, err}, 32'd0);
    send(8'h01);
    send(8'h40);
    for (int i = 0; i < 16384; i++) send(8'(i));
    check("f4_edge_addr", {14'b0, wr_addr}, 32'h07FFF);
    check("f4_edge_err",  {31'b0, err}, 32'd0);
    send(8'h00);
    check("f4_extra_no_wr", {31'b0, wr_en}, 32'd0);
    check("f4_extra_err",   {31'b0, err}, 32'd1);
    finish_frame(8'h00);
    @(posedge clk);
    #1;
    check("f4_loaded", {16'b0, loaded}, 32'h0028);
    check("f4_writes", wr_total - w0, 32'd16384);

    // Abort on the third payload byte of slot 2
    w0 = wr_total; d0 = done_total;
    send(8'h02);
    send(8'h08);
    send(8'h00);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    in_data  = 8'h33;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    check("f5_abort_no_wr", {31'b0, wr_en}, 32'd0);
    check("f5_abort_idle",  {31'b0, busy}, 32'd0);
    check("f5_abort_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("f5_writes", wr_total - w0, 32'd2);
    check("f5_dones",  done_total - d0, 32'd0);
    check("f5_loaded", {16'b0, loaded}, 32'h0028);
    check("f5_err",    {31'b0, err}, 32'd0);

    // Reloading slot 5 drops its loaded bit at LEN_HI
    send(8'h05);
    send(8'h01);
    check("f6_before_hi", {16'b0, loaded}, 32'h0028);
    send(8'h00);
    check("f6_after_hi", {16'b0, loaded}, 32'h0008);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("f6_idle",   {31'b0, busy}, 32'd0);
    check("f6_loaded", {16'b0, loaded}, 32'h0008);

    // Reset in the middle of a payload drops the pending write
    send(8'h03);
    send(8'h02);
    send(8'h00);
    send(8'hAA);
    check("f7_first_wr", {31'b0, wr_en}, 32'd1);
    @(negedge clk);
    in_data  = 8'hBB;
    in_valid = 1'b1;
    resetn   = 1'b0;
    @(posedge clk);
    #1;
    check("f7_rst_wr_en",  {31'b0, wr_en}, 32'd0);
    check("f7_rst_loaded", {16'b0, loaded}, 32'd0);
    check("f7_rst_ready",  {31'b0, in_ready}, 32'd0);
    check("f7_rst_addr",   {14'b0, wr_addr}, 32'd0);
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(posedge clk);
    #1;
    check("f7_idle_busy", {31'b0, busy}, 32'd0);

`ifdef CHECKSUM_EN
    // Good trailer
    send(8'h00);
    send(8'h02);
    send(8'h00);
    send(8'h10);
    send(8'h20);
    send(8'h30);
    @(posedge clk);
    #1;
    check("ck_good_loaded", {16'b0, loaded}, 32'h0001);
    check("ck_good_err",    {31'b0, err}, 32'd0);
    // Bad trailer
    send(8'h00);
    send(8'h02);
    send(8'h00);
    send(8'h10);
    send(8'h20);
    send(8'h31);
    @(posedge clk);
    #1;
    check("ck_bad_err",    {31'b0, err}, 32'd1);
    check("ck_bad_loaded", {16'b0, loaded}, 32'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer-side counterpart of the synchronous ROM blocks: fills ROM images into block RAM from a byte stream (ESP32/OSD SPI bridge) at boot or on user request.
- Parses a small header (slot, length) and emits one RAM write per payload byte.
- Keeps a per-slot "loaded" mask so the CPC memory map knows which ROMs are valid.
- Sits between the SPI byte deserializer and the write port of the ROM/RAM array.

Parameters:
- DATA_WIDTH, 8, payload byte width.
- DEPTH, 16384, bytes per ROM slot.
- ADDRESS_WIDTH, $clog2(DEPTH), in-slot address width.
- SLOTS, 16, number of ROM slots.
- SLOT_WIDTH, $clog2(SLOTS), slot index width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready.
- abort  in  1  drop current load, return to IDLE.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  SLOT_WIDTH+ADDRESS_WIDTH  {slot, offset}.
- wr_data  out  DATA_WIDTH  byte to write.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a load finishes.
- err  out  1  sticky error; cleared by next slot byte accepted in IDLE.
- loaded  out  SLOTS  bit s set after a successful, error-free load of slot s.

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, busy=0, loaded=0, in_ready=0 in the reset cycle and 1 in IDLE afterwards.
- Frame: slot byte, len_lo, len_hi, then L payload bytes.
  - L = {len_hi, len_lo}.
  - L=0 means DEPTH.
- States:
  - IDLE: on transfer, latch slot = in_data[SLOT_WIDTH-1:0], clear err. If in_data >= SLOTS, set err (frame still consumed, no writes). Go to LEN_LO.
  - LEN_LO: on transfer, latch low byte, go to LEN_HI.
  - LEN_HI: on transfer, latch high byte, offset=0, go to DATA.
  - DATA: each transfer issues one write. Remaining count decrements. After the last byte, go to CHK if CHECKSUM_EN is defined, else DONE.
  - DONE: in_ready=0 for exactly one cycle. done=1 that cycle. If err=0, set loaded[slot]. Go to IDLE.
- Write timing:
  - Byte accepted at edge N: wr_en=1, wr_data=byte, wr_addr={slot, offset} registered at edge N (visible cycle N+1, one cycle).
  - offset increments after each write.
  - wr_en=0 in all other cycles.
- Boundary conditions:
  - L > DEPTH: bytes with offset >= DEPTH are accepted but produce no write. err set on the first such byte. Offset never wraps into the next slot.
  - Invalid slot: all payload accepted, wr_en never asserted.
- in_ready: 1 in IDLE/LEN_LO/LEN_HI/DATA/CHK, 0 in DONE and during reset.
- abort:
  - Checked before in_valid, so abort wins a same-cycle transfer. That byte is not consumed, no write.
  - Next state IDLE, no done pulse, loaded unchanged, err unchanged.
  - Re-loading a slot clears its loaded bit when LEN_HI is accepted.
- resetn low mid-frame: immediate return to reset values; a pending wr_en is dropped.

Optional Feature:
- CHECKSUM_EN defined:
  - 8-bit running sum of payload bytes, mod 256.
  - One extra trailer byte is accepted in state CHK.
  - Trailer != sum sets err, so loaded[slot] is not set. DONE follows either way.
- Undefined: no CHK state, no trailer byte, no checksum logic.

Test Plan:
- Reset then frame 03,04,00,AA,BB,CC,DD -> writes 0xC000=AA, 0xC001=BB, 0xC002=CC, 0xC003=DD on consecutive accepted cycles. done pulses once, loaded=0x0008, err=0.
- Slot 05, L=0, 16384 bytes i&0xFF -> last write addr 0x17FFF data FF, loaded[5]=1.
- Slot 20 (>=SLOTS), L=2 -> 2 bytes consumed, no wr_en, err=1, loaded unchanged.
- Slot 01, L=16385 -> 16384 writes, 16385th byte accepted with no write, err=1, loaded[1]=0.
- Slot 02, L=8, abort asserted with in_valid on 3rd payload byte -> 2 writes only, no done, state IDLE, in_ready=1 next cycle.
- CHECKSUM_EN: slot 00, L=2, payload 10,20, trailer 30 -> loaded[0]=1. Trailer 31 -> err=1, loaded[0]=0.
